// File: rtl/adc_capture_ctrl_if.sv
// ADC capture controller bus bundle: ADC sample stream, CPU CSR
// control/status and the DPRAM write port, grouped into one interface.
// The slave modport is the controller side; the master modport is the
// side that drives samples and CSRs and observes status and writes.
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int DEC_W  = 8
);
  logic [DATA_W-1:0] adc_sample_i;
  logic              adc_valid_i;
  logic              adc_trig_i;
  logic              csr_start_i;
  logic              csr_abort_i;
  logic              csr_mode_i;
  logic [DEC_W-1:0]  csr_decim_i;
  logic [ADDR_W-1:0] csr_post_i;
  logic              csr_busy_o;
  logic              csr_done_o;
  logic              csr_wrapped_o;
  logic [ADDR_W-1:0] csr_trig_addr_o;
  logic [ADDR_W:0]   csr_count_o;
  logic              adc_we_o;
  logic [DATA_W-1:0] adc_data_o;
  logic [ADDR_W-1:0] adc_addr_o;

  modport slave (
    input  adc_sample_i, adc_valid_i, adc_trig_i,
    input  csr_start_i, csr_abort_i, csr_mode_i, csr_decim_i, csr_post_i,
    output csr_busy_o, csr_done_o, csr_wrapped_o, csr_trig_addr_o, csr_count_o,
    output adc_we_o, adc_data_o, adc_addr_o
  );

  modport master (
    output adc_sample_i, adc_valid_i, adc_trig_i,
    output csr_start_i, csr_abort_i, csr_mode_i, csr_decim_i, csr_post_i,
    input  csr_busy_o, csr_done_o, csr_wrapped_o, csr_trig_addr_o, csr_count_o,
    input  adc_we_o, adc_data_o, adc_addr_o
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: writes qualified, decimated ADC samples into a
// window [BASE, BASE+DEPTH) of the DPRAM write port. Mode 0 fills the
// window once; mode 1 runs a ring until a trigger, then captures a
// programmable number of post-trigger samples. All outputs are registered.
module adc_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int BASE   = 2048,
  parameter int DEPTH  = 4096,
  parameter int DEC_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  adc_capture_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(BASE + DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W + 1)'(1);
  localparam logic [DEC_W-1:0]  ZERO_D   = {DEC_W{1'b0}};
  localparam logic [DEC_W-1:0]  ONE_D    = DEC_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              capture_s;
  logic              accept_s;
  logic              trig_hit_s;
  logic              start_run_s;
  logic              wrap_s;
  logic [ADDR_W-1:0] post_clamp_s;

  logic [ADDR_W-1:0] wptr_r;
  logic [DEC_W-1:0]  decim_r;
  logic [DEC_W-1:0]  dcnt_r;
  logic [ADDR_W-1:0] post_left_r;
  logic              trig_pend_r;
  logic [ADDR_W-1:0] trig_addr_r;
  logic [ADDR_W:0]   count_r;
  logic              wrapped_r;
  logic              done_r;
  logic              busy_r;
  logic              we_r;
  logic [DATA_W-1:0] data_r;
  logic [ADDR_W-1:0] addr_r;

  assign bus.csr_busy_o      = busy_r;
  assign bus.csr_done_o      = done_r;
  assign bus.csr_wrapped_o   = wrapped_r;
  assign bus.csr_trig_addr_o = trig_addr_r;
  assign bus.csr_count_o     = count_r;
  assign bus.adc_we_o        = we_r;
  assign bus.adc_data_o      = data_r;
  assign bus.adc_addr_o      = addr_r;

  // Post-trigger length larger than the window would overwrite the trigger sample
  always_comb begin
    if (bus.csr_post_i > POST_MAX) begin
      post_clamp_s = POST_MAX;
    end else begin
      post_clamp_s = bus.csr_post_i;
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state, sample acceptance and trigger qualification; abort overrides all
  always_comb begin
    state_nx_s  = state_r;
    capture_s   = 1'b0;
    accept_s    = 1'b0;
    trig_hit_s  = 1'b0;
    start_run_s = 1'b0;
    wrap_s      = (wptr_r == LAST_A);
    if (bus.csr_abort_i) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.csr_start_i) begin
            start_run_s = 1'b1;
            state_nx_s  = bus.csr_mode_i ? ST_ARMED : ST_FILL;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_FILL: begin
          capture_s = 1'b1;
          accept_s  = bus.adc_valid_i && (dcnt_r == ZERO_D);
          if (accept_s && wrap_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_FILL;
          end
        end
        ST_ARMED: begin
          capture_s  = 1'b1;
          accept_s   = bus.adc_valid_i && (dcnt_r == ZERO_D);
          trig_hit_s = accept_s && (trig_pend_r || bus.adc_trig_i);
          if (trig_hit_s) begin
            state_nx_s = (post_left_r == ZERO_A) ? ST_DONE : ST_POST;
          end else begin
            state_nx_s = ST_ARMED;
          end
        end
        ST_POST: begin
          capture_s = 1'b1;
          accept_s  = bus.adc_valid_i && (dcnt_r == ZERO_D);
          if (accept_s && (post_left_r == ONE_A)) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_POST;
          end
        end
        ST_DONE: begin
          if (!bus.csr_start_i) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // DPRAM write port: one registered pulse per accepted sample
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      we_r   <= 1'b0;
      data_r <= {DATA_W{1'b0}};
      addr_r <= BASE_A;
    end else begin
      we_r <= accept_s;
      if (accept_s) begin
        data_r <= bus.adc_sample_i;
        addr_r <= wptr_r;
      end
    end
  end

  // Window write pointer, wrapping inside the window rather than the address space
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wptr_r <= BASE_A;
    end else if (start_run_s) begin
      wptr_r <= BASE_A;
    end else if (accept_s) begin
      wptr_r <= wrap_s ? BASE_A : (wptr_r + ONE_A);
    end
  end

  // Decimation: counter moves on valid samples only, accept when it reads zero
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      decim_r <= ZERO_D;
      dcnt_r  <= ZERO_D;
    end else if (start_run_s) begin
      decim_r <= bus.csr_decim_i;
      dcnt_r  <= ZERO_D;
    end else if (capture_s && bus.adc_valid_i) begin
      dcnt_r <= (dcnt_r == decim_r) ? ZERO_D : (dcnt_r + ONE_D);
    end
  end

  // Trigger latch, trigger address and remaining post-trigger samples
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      post_left_r <= ZERO_A;
      trig_pend_r <= 1'b0;
      trig_addr_r <= ZERO_A;
    end else if (start_run_s) begin
      post_left_r <= post_clamp_s;
      trig_pend_r <= 1'b0;
      trig_addr_r <= ZERO_A;
    end else begin
      if ((state_r == ST_ARMED) && capture_s && bus.adc_trig_i) begin
        trig_pend_r <= 1'b1;
      end
      if (trig_hit_s) begin
        trig_addr_r <= wptr_r;
      end
      if ((state_r == ST_POST) && accept_s) begin
        post_left_r <= post_left_r - ONE_A;
      end
    end
  end

  // Run status: saturating word count, ring wrap flag, sticky done, busy
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count_r   <= {(ADDR_W + 1){1'b0}};
      wrapped_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_FILL) || (state_nx_s == ST_ARMED) ||
                (state_nx_s == ST_POST);
      if (start_run_s) begin
        count_r   <= {(ADDR_W + 1){1'b0}};
        wrapped_r <= 1'b0;
        done_r    <= 1'b0;
      end else begin
        if (accept_s && (count_r != DEPTH_C)) begin
          count_r <= count_r + ONE_C;
        end
        if (accept_s && wrap_s && (state_r != ST_FILL)) begin
          wrapped_r <= 1'b1;
        end
        if (bus.csr_abort_i) begin
          done_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
          done_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Testbench for adc_capture_ctrl: random sample streams, expected writes
// derived from the capture rules over the list of valid samples.
module tb_adc_capture_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int BASE   = 2048;
  localparam int DEPTH  = 4096;
  localparam int DEC_W  = 8;

  logic sys_clk;
  logic sys_rst;

  adc_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEC_W(DEC_W)) bus ();

  adc_capture_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE(BASE), .DEPTH(DEPTH), .DEC_W(DEC_W)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] vs_q[$];
  logic [63:0]       mon_q[$];
  logic [63:0]       exp_q[$];
  int                e_count, e_trig_addr;
  bit                e_wrapped, e_complete;

  int cyc = 0;
  int first_we = 0;
  int last_we = 0;
  int done_gap = -1;
  bit done_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_wr(input int addr, input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(addr);
    return {19'd0, a, d};
  endfunction

  // Write monitor and done-after-last-write gap
  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (bus.adc_we_o) begin
      if (mon_q.size() == 0) first_we <= cyc;
      last_we <= cyc;
      mon_q.push_back({19'd0, bus.adc_addr_o, bus.adc_data_o});
    end
    if (bus.csr_done_o && !done_prev) done_gap <= cyc - last_we;
    done_prev <= bus.csr_done_o;
  end

  // Reference: keep every (decim+1)-th valid sample, stop at window end (mode 0)
  // or trigger sample plus post samples (mode 1); addresses modulo the window.
  task automatic build_expected(input int mode, input int decim, input int post, input int trig_idx);
    int kept, jt, postc;
    kept = 0;
    jt = -1;
    postc = (post > DEPTH - 1) ? DEPTH - 1 : post;
    exp_q.delete();
    for (int i = 0; i < vs_q.size(); i++) begin
      if ((i % (decim + 1)) == 0) begin
        if (mode == 0 && kept == DEPTH) break;
        if (mode == 1 && jt >= 0 && kept == jt + postc + 1) break;
        exp_q.push_back(pack_wr(BASE + (kept % DEPTH), vs_q[i]));
        if (mode == 1 && jt < 0 && trig_idx >= 0 && i >= trig_idx) jt = kept;
        kept++;
      end
    end
    e_complete  = (mode == 0) ? (kept == DEPTH) : (jt >= 0 && kept == jt + postc + 1);
    e_count     = (kept > DEPTH) ? DEPTH : kept;
    e_wrapped   = (mode == 1) && (kept >= DEPTH);
    e_trig_addr = (jt >= 0) ? BASE + (jt % DEPTH) : 0;
  endtask

  task automatic check_reset_values();
    chk("rst_we",        bus.adc_we_o, 0);
    chk("rst_data",      bus.adc_data_o, 0);
    chk("rst_addr",      bus.adc_addr_o, BASE);
    chk("rst_busy",      bus.csr_busy_o, 0);
    chk("rst_done",      bus.csr_done_o, 0);
    chk("rst_wrapped",   bus.csr_wrapped_o, 0);
    chk("rst_trig_addr", bus.csr_trig_addr_o, 0);
    chk("rst_count",     bus.csr_count_o, 0);
  endtask

  task automatic run_case(input int mode, input int decim, input int post, input int trig_vidx,
                          input bit trig_gap, input int vpct, input int abort_at,
                          input int rst_at, input bit chk_span);
    int vcount, n, trig_idx;
    bit ended, trig_done;
    bus.csr_start_i = 1'b0;
    bus.adc_valid_i = 1'b0;
    bus.adc_trig_i  = 1'b0;
    bus.csr_abort_i = 1'b0;
    repeat (3) @(negedge sys_clk);
    vs_q.delete();
    mon_q.delete();
    done_gap = -1;
    bus.csr_start_i = 1'b1;
    bus.csr_mode_i  = mode[0];
    bus.csr_decim_i = DEC_W'(decim);
    bus.csr_post_i  = ADDR_W'(post);
    @(negedge sys_clk);
    chk("busy_on_start", bus.csr_busy_o, 1);
    vcount = 0; n = 0; trig_idx = -1; ended = 1'b0; trig_done = 1'b0;
    while (!ended && n < 40000) begin
      if (abort_at >= 0 && vcount == abort_at) begin
        bus.csr_abort_i  = 1'b1;
        bus.csr_start_i  = 1'b0;
        bus.adc_valid_i  = 1'b1;
        bus.adc_trig_i   = 1'b0;
        bus.adc_sample_i = $urandom;
        @(negedge sys_clk);
        bus.csr_abort_i = 1'b0;
        bus.adc_valid_i = 1'b0;
        chk("busy_after_abort", bus.csr_busy_o, 0);
        chk("we_after_abort", bus.adc_we_o, 0);
        ended = 1'b1;
      end else if (rst_at >= 0 && vcount == rst_at) begin
        sys_rst = 1'b1;
        bus.adc_valid_i = 1'b0;
        bus.adc_trig_i  = 1'b0;
        bus.csr_start_i = 1'b0;
        @(negedge sys_clk);
        check_reset_values();
        sys_rst = 1'b0;
        ended = 1'b1;
      end else begin
        bus.adc_sample_i = $urandom;
        if (mode == 1 && !trig_done && vcount == trig_vidx) begin
          bus.adc_trig_i  = 1'b1;
          bus.adc_valid_i = !trig_gap;
          trig_done = 1'b1;
          trig_idx = vcount;
        end else begin
          bus.adc_trig_i  = (mode == 0) ? ($urandom_range(3) == 0) : 1'b0;
          bus.adc_valid_i = ($urandom_range(99) < vpct);
        end
        if (bus.adc_valid_i) begin
          vs_q.push_back(bus.adc_sample_i);
          vcount++;
        end
        @(negedge sys_clk);
        n++;
        if (bus.csr_done_o) ended = 1'b1;
      end
    end
    chk("no_timeout", ended, 1);
    repeat (16) begin
      bus.adc_valid_i  = 1'($urandom_range(1));
      bus.adc_trig_i   = 1'($urandom_range(1));
      bus.adc_sample_i = $urandom;
      @(negedge sys_clk);
    end
    build_expected(mode, decim, post, trig_idx);
    chk("wr_count", mon_q.size(), exp_q.size());
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) chk("wr", mon_q[i], exp_q[i]);
    if (rst_at < 0) begin
      chk("count",     bus.csr_count_o, e_count);
      chk("wrapped",   bus.csr_wrapped_o, e_wrapped);
      chk("trig_addr", bus.csr_trig_addr_o, e_trig_addr);
      chk("done",      bus.csr_done_o, e_complete && (abort_at < 0));
      chk("busy_end",  bus.csr_busy_o, 0);
      if (e_complete) chk("done_gap", done_gap, 1);
    end
    if (chk_span) chk("we_span", last_we - first_we + 1, DEPTH);
  endtask

  initial begin
    sys_rst = 1'b1;
    bus.adc_sample_i = '0;
    bus.adc_valid_i  = 1'b0;
    bus.adc_trig_i   = 1'b0;
    bus.csr_start_i  = 1'b0;
    bus.csr_abort_i  = 1'b0;
    bus.csr_mode_i   = 1'b0;
    bus.csr_decim_i  = '0;
    bus.csr_post_i   = '0;
    repeat (3) @(negedge sys_clk);
    check_reset_values();
    sys_rst = 1'b0;

    // full one-shot fill, every sample, contiguous writes
    run_case(0, 0, 0, -1, 1'b0, 100, -1, -1, 1'b1);
    // one-shot fill keeping 1 of 4
    run_case(0, 3, 0, -1, 1'b0, 100, -1, -1, 1'b0);
    // ring, trigger on sample 5000, post 1000
    run_case(1, 0, 1000, 5000, 1'b0, 100, -1, -1, 1'b0);
    // ring, post 0, trigger pulse in an invalid cycle
    run_case(1, 0, 0, 37, 1'b1, 60, -1, -1, 1'b0);
    // abort after 100 writes, then a fresh run from BASE
    run_case(0, 0, 0, -1, 1'b0, 100, 100, -1, 1'b0);
    run_case(0, 1, 0, -1, 1'b0, 70, -1, -1, 1'b0);
    // reset during POST
    run_case(1, 0, 3000, 10, 1'b0, 100, -1, 500, 1'b0);
    // post beyond the window clamps to DEPTH-1
    run_case(1, 0, 8000, 20, 1'b0, 100, -1, -1, 1'b0);
    // random ring captures
    for (int k = 0; k < 4; k++) begin
      run_case(1, $urandom_range(4), $urandom_range(150), $urandom_range(300),
               1'($urandom_range(1)), $urandom_range(100, 40), -1, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Parametrised successor of the one-shot ADC-to-DPRAM write controller.
- Writes qualified, optionally decimated ADC samples into a configurable window of the shared DPRAM write port.
- Two modes: one-shot fill, and triggered ring capture with programmable post-trigger length.
- Control and status run through CPU CSRs; the CPU reads results from the other DPRAM port.

Parameters:
- DATA_W, 32, sample and DPRAM data width
- ADDR_W, 13, DPRAM word-address width
- BASE, 2048, first word address of the capture window
- DEPTH, 4096, window length in words; BASE+DEPTH <= 2**ADDR_W; DEPTH >= 2
- DEC_W, 8, decimation field width

Ports:
- sys_clk  in  1  system clock; single clock domain
- sys_rst  in  1  synchronous, active-high reset
- adc_sample_i  in  DATA_W  ADC sample
- adc_valid_i  in  1  sample strobe
- adc_trig_i  in  1  trigger event (ring mode)
- csr_start_i  in  1  level; 1 = run, drop to 0 to re-arm after done
- csr_abort_i  in  1  pulse; stop immediately
- csr_mode_i  in  1  0 = one-shot, 1 = triggered ring
- csr_decim_i  in  DEC_W  keep 1 of every (decim+1) valid samples
- csr_post_i  in  ADDR_W  post-trigger sample count; clamped to DEPTH-1
- csr_busy_o  out  1  state is FILL, ARMED or POST
- csr_done_o  out  1  capture complete
- csr_wrapped_o  out  1  ring address wrapped at least once
- csr_trig_addr_o  out  ADDR_W  word address of the trigger sample
- csr_count_o  out  ADDR_W+1  words written in the current run
- adc_we_o  out  1  DPRAM write enable
- adc_data_o  out  DATA_W  DPRAM write data, registered
- adc_addr_o  out  ADDR_W  DPRAM write address, registered

Behaviour:
- Reset:
  - state = IDLE; all outputs 0, except adc_addr_o = BASE.
  - Reset mid-capture aborts with no further writes.
- States:
  - IDLE: on csr_start_i=1, latch mode, decim and post; clear done, wrapped, count and trig_addr; set wptr=BASE and decim counter=0. Go to FILL (mode 0) or ARMED (mode 1).
  - FILL: write accepted samples. After the write to BASE+DEPTH-1, go to DONE.
  - ARMED: write accepted samples into the ring; wptr wraps BASE+DEPTH-1 -> BASE, and wrapped sets on the first wrap. adc_trig_i is sticky-latched while ARMED. The first accepted sample on or after the latched trigger is the trigger sample: record its address in trig_addr. If post=0, go to DONE; else go to POST.
  - POST: write exactly post more accepted samples, with ring wrap still active, then go to DONE.
  - DONE: done=1, no writes; go to IDLE when csr_start_i=0.
  - Abort (any state): go to IDLE next cycle; done=0; status registers hold; no write after the abort cycle.
- Sample acceptance:
  - A sample is accepted when adc_valid_i=1 and the decim counter = 0.
  - The decim counter advances on every valid sample and wraps at csr_decim. decim=0 accepts every valid sample.
  - Invalid cycles do not advance the counter.
- Write latency:
  - Accepted sample in cycle N -> adc_we_o=1 in cycle N+1, with that sample on adc_data_o and its address on adc_addr_o.
  - adc_we_o is a single-cycle pulse per accepted sample.
- Counters:
  - count increments per write and saturates at DEPTH.
  - Address arithmetic is modulo the window, never modulo 2**ADDR_W.
- Simultaneous events:
  - Abort beats every other event.
  - A trigger arriving together with the last FILL write is ignored; triggers apply only while ARMED.
  - csr_start_i=0 while busy has no effect.
- Status timing: done rises in the cycle after the final write pulse.

Test Plan:
- Mode 0, decim=0, valid every cycle -> 4096 writes at addresses 2048..6143, contiguous adc_we_o, done after the write to 6143, count=4096, wrapped=0.
- Mode 0, decim=3, valid every cycle -> writes every 4th cycle, data = samples 0,4,8,…; done after 4096 writes.
- Mode 1, post=1000, trigger on sample 5000 -> wrapped=1, trig_addr=2048+(5000 mod 4096)=2952, last write at 3952, done, no writes after.
- Mode 1, post=0, trigger pulse in a gap with adc_valid_i=0 -> trigger latched, next accepted sample is the trigger sample, immediate DONE.
- Abort in mid-FILL after 100 writes -> IDLE next cycle, count=100, done=0; a new start restarts at BASE.
- Reset asserted during POST -> all outputs return to reset values and no adc_we_o pulse follows; post > DEPTH-1 clamps to 4095.
